// File: rtl/mips_mem_arbiter_pkg.sv
// Shared MIPS32 constants plus the memory arbiter's
// port-id and state encodings.
package mips_mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } arb_state_e;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_e;

endpackage

// File: rtl/mips_mem_arbiter.sv
// Fetch / load-store arbiter in front of the shared
// word memory, with range check and access timeout.
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int MAX_DM_RUN = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              if_req,
  input  logic [31:0]       if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_err,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [31:0]       dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_err,
  input  logic              halt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam int RW = $clog2(MAX_DM_RUN + 1);
  localparam int TB = $clog2(TIMEOUT + 1);
  localparam int TW = (TB < 4) ? 4 : TB;
  localparam logic [RW-1:0] RUN_MAX  = RW'(MAX_DM_RUN);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  arb_state_e        state_q, state_d;
  port_e             port_q, port_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [RW-1:0]     run_q, run_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic        fetch_win;
  logic [31:0] g_addr;
  logic        g_oor;

  // fetch only beats a pending data request once the run is used up
  assign fetch_win = if_req && (!dm_req || run_q == RUN_MAX);
  assign g_addr    = fetch_win ? if_addr : dm_addr;
  assign g_oor     = |g_addr[31:ADDR_W];

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      port_q  <= PORT_IF;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      run_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      run_q   <= run_d;
      tmo_q   <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    we_d    = we_q;
    err_d   = err_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    run_d   = run_q;
    tmo_d   = tmo_q;
    unique case (state_q)
      S_IDLE: begin
        if (!halt && (if_req || dm_req)) begin
          port_d  = fetch_win ? PORT_IF : PORT_DM;
          we_d    = !fetch_win && dm_we;
          addr_d  = g_addr[ADDR_W-1:0];
          wdata_d = fetch_win ? '0 : dm_wdata;
          rdata_d = '0;
          tmo_d   = '0;
          err_d   = g_oor;
          state_d = g_oor ? S_RESP : S_ACCESS;
          if (fetch_win || !if_req) begin
            run_d = '0;
          end else if (run_q != RUN_MAX) begin
            run_d = run_q + RW'(1);
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          rdata_d = we_q ? '0 : mem_rdata;
          err_d   = 1'b0;
          state_d = S_RESP;
        end else if (tmo_q == TMO_LAST) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy      = state_q != S_IDLE;
  assign mem_req   = state_q == S_ACCESS;
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mem_req ? addr_q : '0;
  assign mem_wdata = mem_req ? wdata_q : '0;

  assign if_ack   = state_q == S_RESP && port_q == PORT_IF;
  assign dm_ack   = state_q == S_RESP && port_q == PORT_DM;
  assign if_rdata = if_ack ? rdata_q : '0;
  assign dm_rdata = dm_ack ? rdata_q : '0;
  assign if_err   = if_ack && err_q;
  assign dm_err   = dm_ack && err_q;

endmodule
